rv32i_multicycle_ctrl: RTL and testbench

Multi-cycle control FSM for the RV32I core. It sequences each instruction through fetch, decode, execute, memory and writeback. It consumes opcode and funct3 from instruction_decoder and branch_taken from the ALU comparator. It drives the datapath enables and muxes, and the unified memory request handshake. It also counts retired instructions and traps on unsupported opcodes.

---
 rtl/rv32i_ctrl_pkg.sv | 50 +++++
 rtl/rv32i_multicycle_ctrl.sv | 174 +++++++++++++++++
 tb/tb_rv32i_multicycle_ctrl.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/rv32i_ctrl_pkg.sv
// Shared encodings for the RV32I multi-cycle controller, the instruction
// decoder and the datapath.
//   state_t      : controller FSM state encoding (also exported on the debug port)
//   OPC_*        : RV32I major opcodes
//   PC_SEL_*     : PC next-value mux encoding
//   WB_SEL_*     : register-file write-back mux encoding
//   opcode_legal : opcodes the core executes; anything else traps
package rv32i_ctrl_pkg;

  typedef enum logic [2:0] {
    FETCH     = 3'd0,
    DECODE    = 3'd1,
    EXECUTE   = 3'd2,
    MEMORY    = 3'd3,
    WRITEBACK = 3'd4,
    TRAP      = 3'd5
  } state_t;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [1:0] PC_SEL_PLUS4  = 2'd0;
  localparam logic [1:0] PC_SEL_TARGET = 2'd1;
  localparam logic [1:0] PC_SEL_JALR   = 2'd2;

  localparam logic [1:0] WB_SEL_ALU = 2'd0;
  localparam logic [1:0] WB_SEL_MDR = 2'd1;
  localparam logic [1:0] WB_SEL_PC4 = 2'd2;
  localparam logic [1:0] WB_SEL_IMM = 2'd3;

  function automatic logic opcode_legal(input logic [6:0] opc);
    logic ok;
    case (opc)
      OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH,
      OPC_LOAD, OPC_STORE, OPC_OP_IMM, OPC_OP, OPC_FENCE: ok = 1'b1;
      default:                                             ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/rv32i_multicycle_ctrl.sv
// Multi-cycle control FSM for the RV32I core. Sequences each instruction
// through fetch/decode/execute/memory/writeback, drives datapath enables and
// muxes plus the unified memory handshake, counts retired instructions and
// traps (stickily) on unsupported opcodes.
//
// Ports:
//   clk, reset           : clock; synchronous active-high reset
//   opcode, funct3       : decoder fields, valid from DECODE onward
//   branch_taken         : ALU compare result, used in EXECUTE for branches
//   mem_ready            : memory completes the current request this cycle
//   mem_req/mem_we       : memory request and store qualifier
//   addr_sel             : 0 = PC, 1 = ALU result as memory address
//   ir_we/mdr_we/pc_we   : register load strobes
//   pc_sel, alu_a_sel    : PC mux and ALU operand-A mux
//   rf_we, wb_sel        : register file write strobe and source mux
//   state, trap, instret : debug state, sticky illegal flag, retire count
//
// state     | meaning
// ----------+----------------------------------------------------------
// FETCH     | read instruction at PC, wait for mem_ready, load IR
// DECODE    | classify opcode; illegal opcodes go to TRAP
// EXECUTE   | ALU op; branches and FENCE retire here
// MEMORY    | data access at ALU address; stores retire here
// WRITEBACK | register write and PC update; instruction retires
// TRAP      | absorbing until reset; all strobes low
module rv32i_multicycle_ctrl
  import rv32i_ctrl_pkg::*;
#(
  parameter int INSTRET_W = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [6:0]           opcode,
  input  logic [2:0]           funct3,
  input  logic                 branch_taken,
  input  logic                 mem_ready,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic                 addr_sel,
  output logic                 ir_we,
  output logic                 mdr_we,
  output logic                 pc_we,
  output logic [1:0]           pc_sel,
  output logic                 alu_a_sel,
  output logic                 rf_we,
  output logic [1:0]           wb_sel,
  output logic [2:0]           state,
  output logic                 trap,
  output logic [INSTRET_W-1:0] instret
);

  state_t               state_q, state_d;
  logic                 trap_q;
  logic [INSTRET_W-1:0] instret_q;
  logic                 retire;

  // funct3 is carried for future trap qualification; no opcode currently
  // depends on it.
  logic unused_funct3;
  assign unused_funct3 = ^funct3;

  always_comb begin
    state_d   = state_q;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    addr_sel  = 1'b0;
    ir_we     = 1'b0;
    mdr_we    = 1'b0;
    pc_we     = 1'b0;
    pc_sel    = PC_SEL_PLUS4;
    alu_a_sel = 1'b0;
    rf_we     = 1'b0;
    wb_sel    = WB_SEL_ALU;
    retire    = 1'b0;

    // Everything stays at its default while reset is high, so an in-flight
    // request is dropped in the same cycle reset arrives.
    if (!reset) begin
      case (state_q)
        FETCH: begin
          mem_req = 1'b1;
          if (mem_ready) begin
            ir_we   = 1'b1;
            state_d = DECODE;
          end
        end

        DECODE: state_d = opcode_legal(opcode) ? EXECUTE : TRAP;

        EXECUTE: begin
          case (opcode)
            OPC_LOAD, OPC_STORE: state_d = MEMORY;
            OPC_BRANCH: begin
              pc_we     = 1'b1;
              alu_a_sel = 1'b1;
              pc_sel    = branch_taken ? PC_SEL_TARGET : PC_SEL_PLUS4;
              retire    = 1'b1;
              state_d   = FETCH;
            end
            OPC_FENCE: begin
              pc_we   = 1'b1;
              retire  = 1'b1;
              state_d = FETCH;
            end
            OPC_AUIPC, OPC_JAL: begin
              alu_a_sel = 1'b1;
              state_d   = WRITEBACK;
            end
            default: state_d = WRITEBACK;
          endcase
        end

        MEMORY: begin
          mem_req  = 1'b1;
          addr_sel = 1'b1;
          mem_we   = (opcode == OPC_STORE);
          if (mem_ready) begin
            if (opcode == OPC_STORE) begin
              pc_we   = 1'b1;
              retire  = 1'b1;
              state_d = FETCH;
            end else begin
              mdr_we  = 1'b1;
              state_d = WRITEBACK;
            end
          end
        end

        WRITEBACK: begin
          rf_we  = 1'b1;
          pc_we  = 1'b1;
          retire = 1'b1;
          case (opcode)
            OPC_LOAD: wb_sel = WB_SEL_MDR;
            OPC_JAL: begin
              wb_sel = WB_SEL_PC4;
              pc_sel = PC_SEL_TARGET;
            end
            OPC_JALR: begin
              wb_sel = WB_SEL_PC4;
              pc_sel = PC_SEL_JALR;
            end
            OPC_LUI: wb_sel = WB_SEL_IMM;
            default: wb_sel = WB_SEL_ALU;
          endcase
          state_d = FETCH;
        end

        TRAP: state_d = TRAP;

        default: state_d = FETCH;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= FETCH;
      trap_q    <= 1'b0;
      instret_q <= '0;
    end else begin
      state_q <= state_d;
      trap_q  <= (state_d == TRAP);
      if (retire) begin
        instret_q <= instret_q + INSTRET_W'(1);
      end
    end
  end

  assign state   = state_q;
  assign trap    = trap_q;
  assign instret = instret_q;

endmodule

// File: tb/tb_rv32i_multicycle_ctrl.sv
// Self-checking bench for rv32i_multicycle_ctrl. The reference is an
// instruction-level schedule: each instruction expands into the list of
// cycles it must take (fetch waits, decode, execute, memory waits,
// writeback) with the outputs each cycle must show. A narrow retire counter
// is used so wrap-around is exercised.
module tb_rv32i_multicycle_ctrl;
  import rv32i_ctrl_pkg::*;

  localparam int IW = 4;

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       addr_sel;
    logic       ir_we;
    logic       mdr_we;
    logic       pc_we;
    logic [1:0] pc_sel;
    logic       alu_a_sel;
    logic       rf_we;
    logic [1:0] wb_sel;
    logic [2:0] st;
    logic       trp;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [6:0]    opcode = 7'd0;
  logic [2:0]    funct3 = 3'd0;
  logic          branch_taken = 1'b0;
  logic          mem_ready = 1'b0;
  logic          mem_req, mem_we, addr_sel, ir_we, mdr_we, pc_we;
  logic [1:0]    pc_sel, wb_sel;
  logic          alu_a_sel, rf_we, trap;
  logic [2:0]    state;
  logic [IW-1:0] instret;

  rv32i_multicycle_ctrl #(.INSTRET_W(IW)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3),
    .branch_taken(branch_taken), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .addr_sel(addr_sel),
    .ir_we(ir_we), .mdr_we(mdr_we), .pc_we(pc_we), .pc_sel(pc_sel),
    .alu_a_sel(alu_a_sel), .rf_we(rf_we), .wb_sel(wb_sel),
    .state(state), .trap(trap), .instret(instret)
  );

  always #5 clk = ~clk;

  // Per-cycle expectation posted by the driver, checked by the compare process.
  exp_t          exp_cur;
  logic [IW-1:0] exp_instret;
  logic          exp_v = 1'b0;
  int            cyc_tot = 0, cyc_pass = 0;
  int            lit_tot = 0, lit_pass = 0;
  int            m_instret = 0;

  // A literal check on instret/trap that must wait until the next edge.
  logic          pend_v = 1'b0;
  logic          pend_is_trap;
  int            pend_want;
  string         pend_name;

  always @(negedge clk) begin
    if (exp_v) begin
      exp_t got;
      got = '{mem_req, mem_we, addr_sel, ir_we, mdr_we, pc_we, pc_sel,
              alu_a_sel, rf_we, wb_sel, state, trap};
      cyc_tot++;
      if (got === exp_cur && instret === exp_instret) cyc_pass++;
      else $display("FAIL cycle t=%0t outputs got=%04h want=%04h instret got=%0d want=%0d",
                    $time, got, exp_cur, instret, exp_instret);
    end
  end

  task automatic check_lit(input string name, input int got, input int want);
    lit_tot++;
    if (got == want) lit_pass++;
    else $display("FAIL %s got=%0d want=%0d", name, got, want);
  endtask

  task automatic step(input logic rst, input logic mr, input logic bt,
                      input logic [6:0] opc, input exp_t e);
    @(posedge clk);
    #1;
    if (pend_v) begin
      check_lit(pend_name, pend_is_trap ? int'(trap) : int'(instret), pend_want);
      pend_v = 1'b0;
    end
    reset        = rst;
    mem_ready    = mr;
    branch_taken = bt;
    opcode       = opc;
    funct3       = 3'($urandom);
    exp_cur      = e;
    exp_instret  = IW'(m_instret);
    exp_v        = 1'b1;
  endtask

  task automatic expect_after(input string name, input logic is_trap, input int want);
    pend_name    = name;
    pend_is_trap = is_trap;
    pend_want    = want;
    pend_v       = 1'b1;
  endtask

  function automatic logic is_legal(input logic [6:0] opc);
    logic [6:0] legal [10] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63,
                               7'h03, 7'h23, 7'h13, 7'h33, 7'h0F};
    foreach (legal[i]) if (legal[i] == opc) return 1'b1;
    return 1'b0;
  endfunction

  // Runs one instruction from its first fetch cycle to retirement (or to the
  // decode cycle for an illegal opcode). fw/mw are memory wait cycles.
  task automatic run_instr(input logic [31:0] insn, input int fw, input int mw,
                           input logic bt, output int ncyc);
    exp_t       e;
    logic [6:0] opc;
    opc  = insn[6:0];
    ncyc = 0;
    for (int i = 0; i < fw; i++) begin
      e = '0; e.mem_req = 1;
      step(0, 0, 1'($urandom), 7'($urandom), e); ncyc++;
    end
    e = '0; e.mem_req = 1; e.ir_we = 1;
    step(0, 1, 1'($urandom), 7'($urandom), e); ncyc++;
    e = '0; e.st = 3'd1;
    step(0, 1'($urandom), 1'($urandom), opc, e); ncyc++;
    if (!is_legal(opc)) return;

    e = '0; e.st = 3'd2;
    if (opc == 7'h63) begin
      e.pc_we = 1; e.alu_a_sel = 1; e.pc_sel = bt ? 2'd1 : 2'd0;
      step(0, 1'($urandom), bt, opc, e); ncyc++;
      m_instret++;
      return;
    end
    if (opc == 7'h0F) begin
      e.pc_we = 1;
      step(0, 1'($urandom), 1'($urandom), opc, e); ncyc++;
      m_instret++;
      return;
    end
    if (opc == 7'h17 || opc == 7'h6F) e.alu_a_sel = 1;
    step(0, 1'($urandom), 1'($urandom), opc, e); ncyc++;

    if (opc == 7'h03 || opc == 7'h23) begin
      for (int i = 0; i <= mw; i++) begin
        e = '0; e.st = 3'd3; e.mem_req = 1; e.addr_sel = 1;
        e.mem_we = (opc == 7'h23);
        if (i == mw) begin
          if (opc == 7'h23) e.pc_we = 1;
          else              e.mdr_we = 1;
        end
        step(0, i == mw, 1'($urandom), opc, e); ncyc++;
      end
      if (opc == 7'h23) begin
        m_instret++;
        return;
      end
    end

    e = '0; e.st = 3'd4; e.rf_we = 1; e.pc_we = 1;
    case (opc)
      7'h03:   e.wb_sel = 2'd1;
      7'h6F:   begin e.wb_sel = 2'd2; e.pc_sel = 2'd1; end
      7'h67:   begin e.wb_sel = 2'd2; e.pc_sel = 2'd2; end
      7'h37:   e.wb_sel = 2'd3;
      default: e.wb_sel = 2'd0;
    endcase
    step(0, 1'($urandom), 1'($urandom), opc, e); ncyc++;
    m_instret++;
  endtask

  task automatic trap_cycles(input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e = '0; e.st = 3'd5; e.trp = 1;
      step(0, 1'($urandom), 1'($urandom), 7'($urandom), e);
    end
  endtask

  // Two reset cycles: the first still shows the pre-reset state/trap/instret
  // with every strobe and select low, the second shows the cleared state.
  task automatic do_reset(input logic [2:0] cur_st, input logic cur_trap);
    exp_t e;
    e = '0; e.st = cur_st; e.trp = cur_trap;
    step(1, 1'($urandom), 1'($urandom), 7'($urandom), e);
    m_instret = 0;
    e = '0;
    step(1, 1'($urandom), 1'($urandom), 7'($urandom), e);
  endtask

  initial begin
    int         n;
    exp_t       e;
    logic [6:0] ops [10] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63,
                             7'h03, 7'h23, 7'h13, 7'h33, 7'h0F};
    logic [6:0] bad [4]  = '{7'h73, 7'h00, 7'h7F, 7'h0B};

    repeat (2) @(posedge clk);
    e = '0;
    step(1, 0, 0, 7'h00, e);

    run_instr(32'h003100B3, 0, 0, 0, n);
    check_lit("add_cycles", n, 4);
    expect_after("add_instret", 0, 1);

    run_instr(32'h01012083, 0, 2, 0, n);
    check_lit("lw_cycles", n, 7);
    expect_after("lw_instret", 0, 2);

    run_instr(32'h00112A23, 0, 0, 0, n);
    check_lit("sw_cycles", n, 4);
    run_instr(32'hFE208EE3, 0, 0, 1, n);
    check_lit("beq_cycles", n, 3);
    expect_after("beq_instret", 0, 4);

    run_instr(32'h020000EF, 0, 0, 0, n);
    run_instr(32'h000100E7, 1, 0, 0, n);
    check_lit("jalr_cycles_1wait", n, 5);
    expect_after("jal_jalr_instret", 0, 6);

    run_instr(32'h00000073, 0, 0, 0, n);
    check_lit("ecall_cycles_to_decode", n, 2);
    trap_cycles(10);
    expect_after("ecall_trap_sticky", 1, 1);
    do_reset(3'd5, 1'b1);
    expect_after("trap_cleared", 1, 0);

    e = '0; e.mem_req = 1;
    step(0, 0, 0, 7'h00, e);
    do_reset(3'd0, 1'b0);
    run_instr(32'h003100B3, 0, 0, 0, n);
    expect_after("restart_instret", 0, 1);

    for (int k = 0; k < 200; k++) begin
      if ($urandom_range(0, 24) == 0) begin
        run_instr({25'h0, bad[$urandom_range(0, 3)]}, $urandom_range(0, 2), 0, 0, n);
        trap_cycles($urandom_range(1, 4));
        do_reset(3'd5, 1'b1);
      end else begin
        run_instr({25'h0, ops[$urandom_range(0, 9)]}, $urandom_range(0, 2),
                  $urandom_range(0, 2), 1'($urandom), n);
      end
    end

    @(posedge clk);
    #1;
    exp_v = 1'b0;
    @(negedge clk);
    $display("%0d/%0d checks passed", cyc_pass + lit_pass, cyc_tot + lit_tot);
    $finish;
  end

endmodule
